layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Sequences one fully connected layer: out[j] = sum_i W[j*N_IN+i] * x[i], for j < N_OUT.
//  Sits between the top-level control and the weight RAM, neuron RAM and MAC datapath.
//  Issues read addresses for weights and inputs, drives MAC clear/enable, and writes each
//  neuron result to the output region. Uses a start/busy/done handshake.
// PARAMETERS
//  ADDR_W    8      width of all address outputs
//  N_IN      4      inputs per neuron (>=1)
//  N_OUT     4      neurons per layer (>=1)
//  MEM_LAT   1      read latency of weight/neuron RAM in cycles (>=1)
//  W_BASE    8'h00  weight region base address
//  IN_BASE   8'h00  input-neuron region base address
//  OUT_BASE  8'h10  output-neuron region base address
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  start        in   1       begin a layer; sampled only in IDLE
//  abort        in   1       synchronous cancel; any state -> IDLE next cycle
//  busy         out  1       high in every state except IDLE
//  done         out  1       one-cycle pulse when the last neuron is written
//  rd_en        out  1       weight/neuron RAM read strobe
//  w_rd_addr    out  ADDR_W  W_BASE + j*N_IN + i
//  in_rd_addr   out  ADDR_W  IN_BASE + i
//  mac_en       out  1       MAC accumulates this cycle (rd_en delayed MEM_LAT)
//  mac_clr      out  1       with mac_en: load the product instead of adding (term i=0)
//  out_we       out  1       output-neuron RAM write strobe
//  out_wr_addr  out  ADDR_W  OUT_BASE + j
// BEHAVIOUR
//  Reset: state=IDLE, i=j=0, delay pipe cleared; rd_en/mac_en/mac_clr/out_we/busy/done=0;
//   w_rd_addr=W_BASE, in_rd_addr=IN_BASE, out_wr_addr=OUT_BASE. All outputs registered.
//  FSM states: IDLE, READ, DRAIN, WRITE, DONE.
//   IDLE : start=1 -> READ with i=0, j=0. A start seen in any other state is ignored.
//   READ : rd_en=1 for N_IN consecutive cycles, i counts 0..N_IN-1; addresses are valid
//          in the same cycle as rd_en. At i=N_IN-1 -> DRAIN.
//   DRAIN: MEM_LAT cycles with rd_en=0; the last mac_en occurs in the final DRAIN cycle.
//   WRITE: one cycle, out_we=1, out_wr_addr=OUT_BASE+j. If j==N_OUT-1 -> DONE,
//          else j+1, i=0 -> READ.
//   DONE : done=1 for one cycle, busy=1 -> IDLE.
//  MAC pipe: mac_en = rd_en delayed by exactly MEM_LAT cycles. mac_clr = (rd_en && i==0)
//   delayed by MEM_LAT cycles; mac_clr is never high without mac_en.
//  Timing: per neuron N_IN+MEM_LAT+1 cycles. For start sampled at edge 0, READ begins
//   in cycle 1 and done is high in cycle 1+N_OUT*(N_IN+MEM_LAT+1).
//  Width: address sums are computed at ADDR_W and wrap modulo 2^ADDR_W without error.
//   i needs clog2(N_IN) bits and j needs clog2(N_OUT) bits, each with a minimum of 1.
//  abort: the next state is IDLE and the delay pipe is flushed. No further mac_en,
//   out_we or done is issued for the cancelled layer. abort has priority over start.
//  reset asserted mid-layer: immediate return to the reset values above. The layer is
//   lost, with no done pulse.
//  N_IN=1: READ lasts one cycle, and that term carries both mac_clr and mac_en.
//  start held high: exactly one layer per IDLE visit. The next layer starts the cycle
//   after DONE if start is still high.
// TESTING
//  T1 defaults, start pulse at cycle 0 -> rd_en cycles 1-4, w_rd_addr 0,1,2,3,
//     in_rd_addr 0,1,2,3; mac_en 2-5; mac_clr 2; out_we cycle 6 addr 0x10.
//  T2 defaults, full layer -> w_rd_addr 0..15 in order; out_we addrs 0x10..0x13 at cycles
//     6,12,18,24; done cycle 25 only; busy cycles 1-25.
//  T3 MEM_LAT=3, N_IN=2, N_OUT=1 -> rd_en cycles 1-2; mac_en 4-5; out_we cycle 6;
//     done cycle 7.
//  T4 abort at cycle 9 of the T2 run -> busy=0 from cycle 10; no mac_en, out_we or done
//     after cycle 10.
//  T5 reset asserted mid-READ, asynchronously between edges -> all outputs return to reset
//     values before the next edge. A new start then restarts at w_rd_addr=0.
//  T6 start pulsed while busy -> ignored; start held high -> back-to-back layers,
//     second READ begins in the cycle after done.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// Control handshake and memory/MAC strobes of the fully connected layer sequencer.
// master = top-level control, slave = the sequencer itself.
interface layer_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] in_rd_addr;
    logic              mac_en;
    logic              mac_clr;
    logic              out_we;
    logic [ADDR_W-1:0] out_wr_addr;

    modport master (
        output start,
        output abort,
        input  busy,
        input  done,
        input  rd_en,
        input  w_rd_addr,
        input  in_rd_addr,
        input  mac_en,
        input  mac_clr,
        input  out_we,
        input  out_wr_addr
    );

    modport slave (
        input  start,
        input  abort,
        output busy,
        output done,
        output rd_en,
        output w_rd_addr,
        output in_rd_addr,
        output mac_en,
        output mac_clr,
        output out_we,
        output out_wr_addr
    );
endinterface

// File: rtl/layer_sequencer.sv
// Sequences one fully connected layer: reads weights/inputs, steers the MAC and writes
// each neuron result. Every output is a flop loaded from the next-state values.
module layer_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                N_IN     = 4,
    parameter int                N_OUT    = 4,
    parameter int                MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0] W_BASE   = ADDR_W'('h00),
    parameter logic [ADDR_W-1:0] IN_BASE  = ADDR_W'('h00),
    parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'('h10)
) (
    input logic              clk,
    input logic              reset,
    layer_sequencer_if.slave bus
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [IW-1:0]     LAST_I   = IW'(N_IN - 1);
    localparam logic [JW-1:0]     LAST_J   = JW'(N_OUT - 1);
    localparam logic [LW-1:0]     LAST_LAT = LW'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(N_IN);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] i;
    logic [IW-1:0] i_next;
    logic [JW-1:0] j;
    logic [JW-1:0] j_next;
    logic [LW-1:0] lat;
    logic [LW-1:0] lat_next;

    logic              rd_en_q;
    logic              rd_en_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic              out_we_q;
    logic              out_we_d;
    logic [ADDR_W-1:0] w_addr_q;
    logic [ADDR_W-1:0] w_addr_d;
    logic [ADDR_W-1:0] in_addr_q;
    logic [ADDR_W-1:0] in_addr_d;
    logic [ADDR_W-1:0] out_addr_q;
    logic [ADDR_W-1:0] out_addr_d;

    logic [MEM_LAT-1:0] en_pipe;
    logic [MEM_LAT-1:0] clr_pipe;
    logic               clr_tap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            lat   <= '0;
        end else begin
            state <= state_next;
            i     <= i_next;
            j     <= j_next;
            lat   <= lat_next;
        end
    end

    // DONE goes straight back to READ when start is still held, so back-to-back
    // layers lose no cycle between done and the next read burst.
    always_comb begin
        state_next = state;
        i_next     = i;
        j_next     = j;
        lat_next   = lat;
        if (bus.abort) begin
            state_next = IDLE;
            i_next     = '0;
            j_next     = '0;
            lat_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_next = READ;
                        i_next     = '0;
                        j_next     = '0;
                    end
                end
                READ: begin
                    if (i == LAST_I) begin
                        state_next = DRAIN;
                        lat_next   = '0;
                    end else begin
                        i_next = i + 1'b1;
                    end
                end
                DRAIN: begin
                    if (lat == LAST_LAT) begin
                        state_next = WRITE;
                    end else begin
                        lat_next = lat + 1'b1;
                    end
                end
                WRITE: begin
                    if (j == LAST_J) begin
                        state_next = DONE;
                    end else begin
                        state_next = READ;
                        j_next     = j + 1'b1;
                        i_next     = '0;
                    end
                end
                DONE: begin
                    i_next     = '0;
                    j_next     = '0;
                    state_next = bus.start ? READ : IDLE;
                end
                default: begin
                    state_next = IDLE;
                    i_next     = '0;
                    j_next     = '0;
                    lat_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        rd_en_d    = (state_next == READ);
        busy_d     = (state_next != IDLE);
        done_d     = (state_next == DONE);
        out_we_d   = (state_next == WRITE);
        w_addr_d   = W_BASE + ADDR_W'(j_next) * STRIDE + ADDR_W'(i_next);
        in_addr_d  = IN_BASE + ADDR_W'(i_next);
        out_addr_d = OUT_BASE + ADDR_W'(j_next);
    end

    // rd_en and i are registered together, so their pairing marks the first term.
    assign clr_tap = rd_en_q && (i == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_we_q   <= 1'b0;
            w_addr_q   <= W_BASE;
            in_addr_q  <= IN_BASE;
            out_addr_q <= OUT_BASE;
            en_pipe    <= '0;
            clr_pipe   <= '0;
        end else begin
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_we_q   <= out_we_d;
            w_addr_q   <= w_addr_d;
            in_addr_q  <= in_addr_d;
            out_addr_q <= out_addr_d;
            if (bus.abort) begin
                en_pipe  <= '0;
                clr_pipe <= '0;
            end else begin
                en_pipe  <= (en_pipe << 1) | MEM_LAT'(rd_en_q);
                clr_pipe <= (clr_pipe << 1) | MEM_LAT'(clr_tap);
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.w_rd_addr   = w_addr_q;
    assign bus.in_rd_addr  = in_addr_q;
    assign bus.mac_en      = en_pipe[MEM_LAT-1];
    assign bus.mac_clr     = clr_pipe[MEM_LAT-1];
    assign bus.out_we      = out_we_q;
    assign bus.out_wr_addr = out_addr_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench: default 4x4 layer on dut_a, MEM_LAT=3/N_IN=2/N_OUT=1 layer on dut_b.
// Cycle c is the interval after edge c, where edge 0 samples start; outputs read at negedge.
module tb_layer_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    layer_sequencer_if #(.ADDR_W(8)) bus_a ();
    layer_sequencer_if #(.ADDR_W(8)) bus_b ();

    layer_sequencer dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    layer_sequencer #(
        .N_IN    (2),
        .N_OUT   (1),
        .MEM_LAT (3)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // flag vector order: {busy, done, rd_en, mac_en, mac_clr, out_we}
    logic [5:0] flags_a;
    logic [5:0] flags_b;
    assign flags_a = {bus_a.busy, bus_a.done, bus_a.rd_en, bus_a.mac_en, bus_a.mac_clr, bus_a.out_we};
    assign flags_b = {bus_b.busy, bus_b.done, bus_b.rd_en, bus_b.mac_en, bus_b.mac_clr, bus_b.out_we};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Default layer: 6 cycles per neuron (4 reads, 1 drain, 1 write), done in cycle 25.
    function automatic logic [5:0] expFlags(input int rel);
        int         p;
        logic [5:0] f;
        f = 6'b000000;
        if (rel >= 1 && rel <= 24) begin
            p    = (rel - 1) % 6;
            f[5] = 1'b1;
            f[3] = (p < 4);
            f[2] = (p >= 1 && p <= 4);
            f[1] = (p == 1);
            f[0] = (p == 5);
        end else if (rel == 25) begin
            f = 6'b110000;
        end
        return f;
    endfunction

    task automatic checkCycleA(input string name, input int c, input int rel);
        logic [5:0] f;
        int         n;
        int         p;
        f = expFlags(rel);
        checkOutput($sformatf("%s c%0d flags", name, c), 32'(flags_a), 32'(f));
        if (rel >= 1 && rel <= 24) begin
            n = (rel - 1) / 6;
            p = (rel - 1) % 6;
            if (f[3]) begin
                checkOutput($sformatf("%s c%0d w_rd_addr", name, c), 32'(bus_a.w_rd_addr), 32'(n * 4 + p));
                checkOutput($sformatf("%s c%0d in_rd_addr", name, c), 32'(bus_a.in_rd_addr), 32'(p));
            end
            if (f[0]) begin
                checkOutput($sformatf("%s c%0d out_wr_addr", name, c), 32'(bus_a.out_wr_addr), 32'(16 + n));
            end
        end
    endtask

    // Must be entered at a negedge: that negedge is cycle 0 and start is sampled at edge 0.
    task automatic applyStimulus(input string name, input int abort_at, input int pulse_at,
                                 input int hold_until, input int last);
        int rel;
        bus_a.start = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            rel = c;
            if (hold_until > 25 && c > 25) rel = c - 25;
            if (abort_at > 0 && c > abort_at) rel = 0;
            checkCycleA(name, c, rel);
            bus_a.start = (c < hold_until) || (c == pulse_at);
            bus_a.abort = (c == abort_at);
        end
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
    endtask

    logic [5:0] exp_b [1:9];

    initial begin
        exp_b = '{6'b101000, 6'b101000, 6'b100000, 6'b100110, 6'b100100,
                  6'b100001, 6'b110000, 6'b000000, 6'b000000};
        reset       = 1'b1;
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        bus_b.start = 1'b0;
        bus_b.abort = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset flags", 32'(flags_a), 32'(0));
        checkOutput("reset w_rd_addr", 32'(bus_a.w_rd_addr), 32'h00);
        checkOutput("reset in_rd_addr", 32'(bus_a.in_rd_addr), 32'h00);
        checkOutput("reset out_wr_addr", 32'(bus_a.out_wr_addr), 32'h10);
        reset = 1'b0;
        @(negedge clk);

        bus_a.start = 1'b1;
        bus_a.abort = 1'b1;
        @(negedge clk);
        checkOutput("abort over start", 32'(flags_a), 32'(0));
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        @(negedge clk);

        applyStimulus("T2", 0, 0, 1, 28);
        applyStimulus("T4", 9, 0, 1, 30);
        applyStimulus("T6pulse", 0, 10, 1, 28);
        applyStimulus("T6hold", 0, 0, 27, 52);

        bus_b.start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            checkOutput($sformatf("T3 c%0d flags", c), 32'(flags_b), 32'(exp_b[c]));
            if (c <= 2) begin
                checkOutput($sformatf("T3 c%0d w_rd_addr", c), 32'(bus_b.w_rd_addr), 32'(c - 1));
                checkOutput($sformatf("T3 c%0d in_rd_addr", c), 32'(bus_b.in_rd_addr), 32'(c - 1));
            end
            if (c == 6) checkOutput("T3 out_wr_addr", 32'(bus_b.out_wr_addr), 32'h10);
        end

        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("T5 pre-reset flags", 32'(flags_a), 32'(6'b101100));
        checkOutput("T5 pre-reset w_rd_addr", 32'(bus_a.w_rd_addr), 32'h02);
        #2 reset = 1'b1;
        #1;
        checkOutput("T5 async flags", 32'(flags_a), 32'(0));
        checkOutput("T5 async w_rd_addr", 32'(bus_a.w_rd_addr), 32'h00);
        checkOutput("T5 async in_rd_addr", 32'(bus_a.in_rd_addr), 32'h00);
        checkOutput("T5 async out_wr_addr", 32'(bus_a.out_wr_addr), 32'h10);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("T5 idle after reset", 32'(flags_a), 32'(0));
        applyStimulus("T5restart", 0, 0, 1, 27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
